// File: rtl/checkpoint_ctrl.sv
// Circular-buffer allocator for rename checkpoints: save, in-order free, mispredict restore, flush.
// Optional stalled-save counter is enabled with `define CHECKPOINT_CTRL_STALL_STATS_EN.
module checkpoint_ctrl #(
    parameter  int CHECKPOINT_COUNT     = 8,
    parameter  int CHECKPOINT_THRESHOLD = 3,
    localparam int IDX_W                = $clog2(CHECKPOINT_COUNT),
    localparam int CNT_W                = IDX_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             save_valid,
    output logic             save_ready,
    output logic [IDX_W-1:0] save_index,
    input  logic             free_valid,
    input  logic             restore_valid,
    input  logic [IDX_W-1:0] restore_index,
    input  logic             flush_valid,
    output logic [CNT_W-1:0] free_count,
    output logic             low_avail,
    output logic             illegal_err,
    output logic [15:0]      stall_count
);

    logic [IDX_W-1:0]            head_q, head_d;
    logic [IDX_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CHECKPOINT_COUNT-1:0] valid_q, valid_d;
    logic                        err_q, err_d;
    logic                        save_fire;
    logic                        free_fire;

    // A retiring free opens a slot in the same cycle, so a full buffer can still take a save.
    assign save_ready = ((count_q < CNT_W'(CHECKPOINT_COUNT)) | free_valid)
                        & ~restore_valid & ~flush_valid;
    assign save_fire  = save_valid & save_ready;
    assign free_fire  = free_valid & (count_q != '0);
    assign save_index = tail_q;
    assign free_count = CNT_W'(CHECKPOINT_COUNT) - count_q;
    assign low_avail  = (free_count <= CNT_W'(CHECKPOINT_THRESHOLD));
    assign illegal_err = err_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (flush_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (free_valid && (count_q == '0)) begin
                err_d = 1'b1;
            end
            if (free_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + IDX_W'(1);
                count_d         = count_q - CNT_W'(1);
            end
            if (restore_valid) begin
                if (!valid_q[restore_index] || (free_fire && (restore_index == head_q))) begin
                    err_d = 1'b1;
                end else begin
                    // Offsets from head wrap at IDX_W bits; anything at or beyond the restored slot is dropped.
                    for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
                        if ((IDX_W'(i) - head_d) >= (restore_index - head_d)) begin
                            valid_d[i] = 1'b0;
                        end
                    end
                    tail_d  = restore_index;
                    count_d = {1'b0, restore_index - head_d};
                end
            end else if (save_fire) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + IDX_W'(1);
                count_d         = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef CHECKPOINT_CTRL_STALL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (save_valid && !save_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
